// File: rtl/oam_dma_controller_pkg.sv
// Shared definitions for the OAM DMA controller: state encoding,
// register select, transfer length and fixed address pages.
package oam_dma_controller_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE    = 2'd0,
    DMA_READ    = 2'd1,
    DMA_CAPTURE = 2'd2,
    DMA_WRITE   = 2'd3
  } dmaState_t;

  localparam logic [3:0]  DMA_REG_SEL = 4'h6;
  localparam int          OAM_LEN     = 160;
  localparam logic [7:0]  OAM_LAST    = 8'(OAM_LEN - 1);
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam logic [7:0]  HIGH_PAGE   = 8'hFF;
  localparam logic [7:0]  ECHO_START  = 8'hE0;

  // Pages E0..FF mirror C0..DF (echo RAM), so the DMA reads the real copy.
  function automatic logic [7:0] effectiveSource(input logic [7:0] src);
    return (src >= ECHO_START) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_mux.sv
// Combinational ownership mux for the single mmu CPU-side port.
// The CPU owns the port when idle or when it touches the high page;
// otherwise the DMA drives it and off-page CPU reads see 8'hFF.
module oam_dma_mux
  import oam_dma_controller_pkg::*;
(
  input  dmaState_t   state,
  input  logic        cpuWindow,
  input  logic [7:0]  effSrc,
  input  logic [7:0]  idx,
  input  logic [7:0]  dataReg,
  input  logic [15:0] cpuAddr,
  input  logic        cpuWe,
  input  logic [7:0]  cpuData,
  input  logic        cpuReadRequest,
  input  logic [7:0]  mmuReadData,
  output logic [15:0] mmuAddr,
  output logic        mmuWe,
  output logic [7:0]  mmuData,
  output logic        mmuReadRequest,
  output logic [7:0]  cpuReadData
);

  logic dmaActive;
  logic dmaOwnsPort;

  assign dmaActive   = (state != DMA_IDLE);
  assign dmaOwnsPort = dmaActive && !cpuWindow;

  // Default to CPU pass-through, then let the DMA take the port when it owns it.
  always_comb begin
    mmuAddr        = cpuAddr;
    mmuWe          = cpuWe;
    mmuData        = cpuData;
    mmuReadRequest = cpuReadRequest;
    cpuReadData    = mmuReadData;
    if (dmaActive && (cpuAddr[15:8] != HIGH_PAGE)) begin
      cpuReadData = 8'hFF;
    end
    if (dmaOwnsPort) begin
      mmuAddr        = {effSrc, idx};
      mmuWe          = 1'b0;
      mmuData        = dataReg;
      mmuReadRequest = 1'b0;
      case (state)
        DMA_READ:  mmuReadRequest = 1'b1;
        DMA_WRITE: begin
          mmuAddr = OAM_BASE + {8'h00, idx};
          mmuWe   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies 160 bytes from {src,8'h00} to FE00..FE9F,
// three cycles per byte, yielding the mmu port to high-page CPU accesses.
//
// state       | meaning
// ------------+-------------------------------------------------------
// DMA_IDLE    | no transfer; mmu port is pure CPU pass-through
// DMA_READ    | present source address {effsrc,idx} with read request
// DMA_CAPTURE | latch mmu read data into dataReg
// DMA_WRITE   | write dataReg to FE00+idx; finish or advance idx
module oam_dma_controller
  import oam_dma_controller_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iMcuWe,
  input  logic [3:0]  iMcuRegSelect,
  input  logic [7:0]  iMcuWriteData,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuReadRequest,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMmuAddr,
  output logic        oMmuWe,
  output logic [7:0]  oMmuData,
  output logic        oMmuReadRequest,
  input  logic [7:0]  iMmuReadData,
  output logic        oDmaBusy,
  output logic        oDmaDone
);

  dmaState_t  state;
  logic [7:0] idx;
  logic [7:0] src;
  logic [7:0] dataReg;
  logic       heldCapture;
  logic       trigger;
  logic       cpuWindow;
  logic       stall;

  assign trigger   = iMcuWe && (iMcuRegSelect == DMA_REG_SEL);
  assign cpuWindow = (iCpuAddr[15:8] == HIGH_PAGE) && (iCpuWe || iCpuReadRequest);
  assign stall     = cpuWindow && (state != DMA_IDLE);

  // Transfer FSM with registered busy/done; a trigger always restarts from idx 0.
  // mmu read data is only valid the cycle after READ, so a stall landing on
  // CAPTURE grabs the byte immediately and only the state advance waits.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state       <= DMA_IDLE;
      idx         <= 8'h00;
      src         <= 8'h00;
      dataReg     <= 8'h00;
      heldCapture <= 1'b0;
      oDmaBusy    <= 1'b0;
      oDmaDone    <= 1'b0;
    end else begin
      oDmaDone <= 1'b0;
      if (trigger) begin
        src         <= iMcuWriteData;
        idx         <= 8'h00;
        state       <= DMA_READ;
        heldCapture <= 1'b0;
        oDmaBusy    <= 1'b1;
      end else if (stall) begin
        if ((state == DMA_CAPTURE) && !heldCapture) begin
          dataReg     <= iMmuReadData;
          heldCapture <= 1'b1;
        end
      end else begin
        case (state)
          DMA_READ: state <= DMA_CAPTURE;
          DMA_CAPTURE: begin
            if (!heldCapture) dataReg <= iMmuReadData;
            heldCapture <= 1'b0;
            state       <= DMA_WRITE;
          end
          DMA_WRITE: begin
            if (idx == OAM_LAST) begin
              state    <= DMA_IDLE;
              oDmaBusy <= 1'b0;
              oDmaDone <= 1'b1;
            end else begin
              idx   <= idx + 8'd1;
              state <= DMA_READ;
            end
          end
          default: ;
        endcase
      end
    end
  end

  oam_dma_mux uMux (
    .state          (state),
    .cpuWindow      (cpuWindow),
    .effSrc         (effectiveSource(src)),
    .idx            (idx),
    .dataReg        (dataReg),
    .cpuAddr        (iCpuAddr),
    .cpuWe          (iCpuWe),
    .cpuData        (iCpuData),
    .cpuReadRequest (iCpuReadRequest),
    .mmuReadData    (iMmuReadData),
    .mmuAddr        (oMmuAddr),
    .mmuWe          (oMmuWe),
    .mmuData        (oMmuData),
    .mmuReadRequest (oMmuReadRequest),
    .cpuReadData    (oCpuData)
  );

endmodule
